relu_maxpool: RTL

- Downstream stage of the convolution engine; consumes its raster-order valid-output stream (M x M signed fixed-point words).
- Per input word: adds a per-map bias with saturation, then applies ReLU.
- Then performs 2x2 stride-2 max pooling and emits an (M/2) x (M/2) raster stream with a valid strobe and a frame-done flag, feeding the next layer or the flattening buffer.

---
 rtl/cnn_pkg.sv | 33 +++
 rtl/bias_relu.sv | 30 +++
 rtl/relu_maxpool.sv | 119 +++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared fixed-point types, limits, saturating add and stage FSM states
// Shared by the convolver, relu_maxpool and later CNN stages.
//   fix_t      : signed N-bit word, Q fractional bits
//   FIX_MAX/MIN: representable extremes of fix_t
//   sat_add    : a + b clamped to [FIX_MIN, FIX_MAX]
//   state_t    : IDLE / RUN / DONE frame-stage states
package cnn_pkg;

  localparam int N = 16;
  localparam int Q = 12;

  typedef logic signed [N-1:0] fix_t;

  localparam fix_t FIX_MAX = fix_t'({1'b0, {(N-1){1'b1}}});
  localparam fix_t FIX_MIN = fix_t'({1'b1, {(N-1){1'b0}}});

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic fix_t sat_add(input fix_t a, input fix_t b);
    logic signed [N:0] s;
    s = {a[N-1], a} + {b[N-1], b};
    // The two top bits of the N+1 bit sum disagree only on overflow.
    if (s[N] != s[N-1]) begin
      return s[N] ? FIX_MIN : FIX_MAX;
    end
    return s[N-1:0];
  endfunction

endpackage

// File: rtl/bias_relu.sv
// rtl/bias_relu.sv - combinational saturating bias add followed by ReLU
// Ports:
//   conv_i : signed N-bit data word
//   bias_i : signed N-bit bias, same fixed-point format as conv_i
//   relu_o : max(0, min(conv_i + bias_i, 2^(N-1)-1))
module bias_relu #(
  parameter int N = 16
) (
  input  logic signed [N-1:0] conv_i,
  input  logic signed [N-1:0] bias_i,
  output logic signed [N-1:0] relu_o
);

  logic signed [N:0] sum;

  assign sum = {conv_i[N-1], conv_i} + {bias_i[N-1], bias_i};

  // sum[N] is the true sign. A non-negative sum with bit N-1 set exceeds
  // the positive range and clamps; negatives (including negative
  // overflow) rectify to zero.
  always_comb begin
    relu_o = sum[N-1:0];
    if (sum[N]) begin
      relu_o = '0;
    end else if (sum[N-1]) begin
      relu_o = {1'b0, {(N-1){1'b1}}};
    end
  end

endmodule

// File: rtl/relu_maxpool.sv
// rtl/relu_maxpool.sv - bias + ReLU, then 2x2 stride-2 max pooling of an M x M raster stream
// Ports:
//   clk_i       : clock, rising edge
//   rst_ni      : asynchronous active-low reset
//   en_i        : frame enable (IDLE -> RUN, DONE -> IDLE when low)
//   conv_i      : signed convolution result, raster order
//   val_conv_i  : conv_i valid this cycle
//   bias_i      : signed per-map bias, stable for the frame
//   pool_o      : pooled, rectified result (holds between strobes)
//   val_pool_o  : one-cycle strobe per pooled output
//   done_pool_o : high while the frame is complete (DONE state)
module relu_maxpool #(
  parameter int M = 24,
  parameter int N = 16,
  parameter int Q = 12
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [N-1:0] conv_i,
  input  logic         val_conv_i,
  input  logic [N-1:0] bias_i,
  output logic [N-1:0] pool_o,
  output logic         val_pool_o,
  output logic         done_pool_o
);
  import cnn_pkg::*;

  if (M % 2 != 0) begin : g_m_odd
    $error("relu_maxpool: M must be even");
  end

  localparam int HALF = M / 2;
  localparam int CW   = $clog2(M);
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  state_t              state;
  logic [CW-1:0]       col;
  logic [CW-1:0]       row;
  logic signed [N-1:0] relu;
  logic signed [N-1:0] h_reg;
  logic signed [N-1:0] hmax;
  logic signed [N-1:0] vmax;
  logic signed [N-1:0] row_buf [HALF];
  logic                accept;
  logic [CW-2:0]       bidx;

  bias_relu #(.N(N)) u_bias_relu (
    .conv_i (conv_i),
    .bias_i (bias_i),
    .relu_o (relu)
  );

  assign accept = (state == ST_RUN) && val_conv_i;
  assign bidx   = col[CW-1:1];
  assign hmax   = (relu > h_reg) ? relu : h_reg;
  assign vmax   = (row_buf[bidx] > hmax) ? row_buf[bidx] : hmax;

  // Pooling storage carries no reset: every entry is written on an even
  // column/row before the odd column/row that reads it.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      if (!col[0]) begin
        h_reg <= relu;
      end else if (!row[0]) begin
        row_buf[bidx] <= hmax;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      col         <= '0;
      row         <= '0;
      pool_o      <= '0;
      val_pool_o  <= 1'b0;
      done_pool_o <= 1'b0;
    end else begin
      val_pool_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en_i) begin
            state <= ST_RUN;
            col   <= '0;
            row   <= '0;
          end
        end
        ST_RUN: begin
          if (val_conv_i) begin
            if (col == LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            // Bottom-right pixel of a 2x2 window completes the output.
            if (col[0] && row[0]) begin
              pool_o     <= vmax;
              val_pool_o <= 1'b1;
            end
            if (col == LAST && row == LAST) begin
              state       <= ST_DONE;
              done_pool_o <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (!en_i) begin
            state       <= ST_IDLE;
            done_pool_o <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
